// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared state encoding, last-owner constants and counter sizing for the arbiter
package arb_pkg;

    // Grant state; the encoding is one-hot-or-zero so gnt_a/gnt_b map straight onto it.
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        GNT_A = 2'b01,
        GNT_B = 2'b10
    } arb_state_t;

    // Value of the `last` register when A was the most recent owner.
    localparam logic ARB_LAST_A = 1'b1;
    localparam logic ARB_LAST_B = 1'b0;

    // Hold counter width: enough bits to count up to max_hold, never narrower than 1.
    function automatic int hold_width(input int max_hold);
        int w;
        w = $clog2(max_hold + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/mux2a1.sv
// rtl/mux2a1.sv - two-input nbits-wide mux, sel=1 passes a, sel=0 passes b
module mux2a1 #(
    parameter int nbits = 32
) (
    input  logic [nbits-1:0] a,
    input  logic [nbits-1:0] b,
    input  logic             sel,
    output logic [nbits-1:0] salida
);

    // Pure combinational select; no extension or truncation of the data path.
    assign salida = sel ? a : b;

endmodule

// File: rtl/arbitro_mux2.sv
// rtl/arbitro_mux2.sv - round-robin two-requester arbiter with bounded hold driving a shared mux
module arbitro_mux2
    import arb_pkg::*;
#(
    parameter int nbits    = 32,
    parameter int MAX_HOLD = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_a,
    input  logic             req_b,
    input  logic [nbits-1:0] dato_a,
    input  logic [nbits-1:0] dato_b,
    output logic             gnt_a,
    output logic             gnt_b,
    output logic             sel,
    output logic [nbits-1:0] salida,
    output logic             valido
);

    localparam int              HOLD_W    = hold_width(MAX_HOLD);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);
    localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);

    arb_state_t        state;
    arb_state_t        state_nx;
    logic [HOLD_W-1:0] hold_cnt;
    logic [HOLD_W-1:0] hold_cnt_nx;
    logic              last_q;
    logic              last_nx;
    logic              sel_nx;
    logic              at_limit;

    assign at_limit = (hold_cnt == HOLD_LAST);

    // Next-state, hold counter and last-owner decisions from the current grant and requests.
    always_comb begin
        state_nx    = state;
        hold_cnt_nx = hold_cnt;
        last_nx     = last_q;
        sel_nx      = sel;

        case (state)
            IDLE: begin
                hold_cnt_nx = '0;
                // On a tie, the requester that did not own the resource last wins.
                if (req_a && (!req_b || (last_q == ARB_LAST_B))) begin
                    state_nx = GNT_A;
                end else if (req_b) begin
                    state_nx = GNT_B;
                end
            end

            GNT_A: begin
                if (!req_a) begin
                    // Hand straight over to B when it is waiting; no idle bubble.
                    state_nx = req_b ? GNT_B : IDLE;
                end else if (at_limit && req_b) begin
                    state_nx = GNT_B;
                end else begin
                    // Alone at the limit the tenure simply restarts.
                    hold_cnt_nx = at_limit ? '0 : hold_cnt + HOLD_ONE;
                end
            end

            GNT_B: begin
                if (!req_b) begin
                    state_nx = req_a ? GNT_A : IDLE;
                end else if (at_limit && req_a) begin
                    state_nx = GNT_A;
                end else begin
                    hold_cnt_nx = at_limit ? '0 : hold_cnt + HOLD_ONE;
                end
            end

            default: begin
                state_nx    = IDLE;
                hold_cnt_nx = '0;
            end
        endcase

        // Entering a grant (from IDLE or from the other owner) starts a fresh tenure.
        if ((state_nx != state) && (state_nx != IDLE)) begin
            hold_cnt_nx = '0;
            last_nx     = (state_nx == GNT_A) ? ARB_LAST_A : ARB_LAST_B;
        end

        // sel follows the owner and is frozen while idle so salida does not glitch.
        if (state_nx == GNT_A) begin
            sel_nx = 1'b1;
        end else if (state_nx == GNT_B) begin
            sel_nx = 1'b0;
        end
    end

    // State, counter, last owner and the registered grant/select outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            hold_cnt <= '0;
            last_q   <= ARB_LAST_B;
            gnt_a    <= 1'b0;
            gnt_b    <= 1'b0;
            sel      <= 1'b0;
        end else begin
            state    <= state_nx;
            hold_cnt <= hold_cnt_nx;
            last_q   <= last_nx;
            gnt_a    <= (state_nx == GNT_A);
            gnt_b    <= (state_nx == GNT_B);
            sel      <= sel_nx;
        end
    end

    assign valido = gnt_a | gnt_b;

    mux2a1 #(
        .nbits (nbits)
    ) u_mux (
        .a      (dato_a),
        .b      (dato_b),
        .sel    (sel),
        .salida (salida)
    );

endmodule

// File: tb/tb_arbitro_mux2.sv
// tb/tb_arbitro_mux2.sv - self-checking bench for arbitro_mux2 with a tenure-based reference model
module tb_arbitro_mux2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_a;
    logic        req_b;
    logic [31:0] dato_a;
    logic [31:0] dato_b;

    logic        gnt_a4, gnt_b4, sel4, valido4;
    logic [31:0] salida4;
    logic        gnt_a8, gnt_b8, sel8, valido8;
    logic [31:0] salida8;

    logic [35:0] obs [2];

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: owner 0=none 1=A 2=B, tenure = cycles owned in the current run.
    int m_own  [2];
    int m_ten  [2];
    int m_last [2];
    bit m_sel  [2];
    int maxh   [2] = '{4, 8};

    always #5 clk = ~clk;

    arbitro_mux2 #(.nbits(32), .MAX_HOLD(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .req_a(req_a), .req_b(req_b),
        .dato_a(dato_a), .dato_b(dato_b),
        .gnt_a(gnt_a4), .gnt_b(gnt_b4), .sel(sel4), .salida(salida4), .valido(valido4)
    );

    arbitro_mux2 #(.nbits(32), .MAX_HOLD(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .req_a(req_a), .req_b(req_b),
        .dato_a(dato_a), .dato_b(dato_b),
        .gnt_a(gnt_a8), .gnt_b(gnt_b8), .sel(sel8), .salida(salida8), .valido(valido8)
    );

    assign obs[0] = {gnt_a4, gnt_b4, sel4, valido4, salida4};
    assign obs[1] = {gnt_a8, gnt_b8, sel8, valido8, salida8};

    function automatic void model_reset();
        for (int i = 0; i < 2; i++) begin
            m_own[i]  = 0;
            m_ten[i]  = 0;
            m_last[i] = 2;
            m_sel[i]  = 1'b0;
        end
    endfunction

    function automatic void model_advance(input bit ra, input bit rb);
        for (int i = 0; i < 2; i++) begin
            int nown;
            bit mine, oth;
            nown = m_own[i];
            if (m_own[i] == 0) begin
                if (ra && rb)  nown = (m_last[i] == 1) ? 2 : 1;
                else if (ra)   nown = 1;
                else if (rb)   nown = 2;
                if (nown != 0) m_ten[i] = 1;
            end else begin
                mine = (m_own[i] == 1) ? ra : rb;
                oth  = (m_own[i] == 1) ? rb : ra;
                if (mine && (!oth || m_ten[i] < maxh[i])) begin
                    m_ten[i] = (m_ten[i] == maxh[i]) ? 1 : m_ten[i] + 1;
                end else if (oth) begin
                    nown     = 3 - m_own[i];
                    m_ten[i] = 1;
                end else begin
                    nown = 0;
                end
            end
            m_own[i] = nown;
            if (nown != 0) begin
                m_last[i] = nown;
                m_sel[i]  = (nown == 1);
            end
        end
    endfunction

    function automatic logic [35:0] exp_vec(input int i);
        logic s;
        s = m_sel[i];
        return {(m_own[i] == 1), (m_own[i] == 2), s, (m_own[i] != 0), (s ? dato_a : dato_b)};
    endfunction

    task automatic tick();
        @(posedge clk);
        if (rst_n) model_advance(req_a, req_b);
        #1;
    endtask

    task automatic do_reset();
        req_a = 1'b0;
        req_b = 1'b0;
        rst_n = 1'b0;
        model_reset();
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n  = 1'b0;
        req_a  = 1'b0;
        req_b  = 1'b0;
        dato_a = 32'h1111_2222;
        dato_b = 32'h3333_4444;
        model_reset();
        tick();
        tick();
        for (int i = 0; i < 2; i++) begin
            n_cmp++;
            if (obs[i] !== {4'b0000, 32'h3333_4444}) begin
                n_fail++;
                $display("FAIL reset dut%0d: got %h expected %h", i, obs[i], {4'b0000, 32'h3333_4444});
            end
        end
        rst_n = 1'b1;
    endtask

    task automatic test_single_a();
        do_reset();
        dato_a = 32'hA5A5_0001;
        dato_b = 32'h0000_BEEF;
        req_a  = 1'b1;
        tick();
        for (int i = 0; i < 2; i++) begin
            n_cmp++;
            if (obs[i] !== {4'b1011, 32'hA5A5_0001}) begin
                n_fail++;
                $display("FAIL single_a dut%0d: got %h expected %h", i, obs[i], {4'b1011, 32'hA5A5_0001});
            end
        end
        tick();
        n_cmp++;
        if (gnt_b4 !== 1'b0 || gnt_a4 !== 1'b1) begin
            n_fail++;
            $display("FAIL single_a_hold: got gnt_a=%b gnt_b=%b expected gnt_a=1 gnt_b=0", gnt_a4, gnt_b4);
        end
    endtask

    task automatic test_rotation();
        do_reset();
        req_a = 1'b1;
        req_b = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            bit want_a;
            tick();
            want_a = (((k - 1) / 4) % 2) == 0;
            n_cmp++;
            if (gnt_a4 !== want_a || gnt_b4 !== !want_a) begin
                n_fail++;
                $display("FAIL rotation cyc%0d: got gnt_a=%b gnt_b=%b expected gnt_a=%b gnt_b=%b",
                         k, gnt_a4, gnt_b4, want_a, !want_a);
            end
            n_cmp++;
            if (obs[1] !== exp_vec(1)) begin
                n_fail++;
                $display("FAIL rotation8 cyc%0d: got %h expected %h", k, obs[1], exp_vec(1));
            end
        end
    endtask

    task automatic test_handoff();
        do_reset();
        dato_a = 32'h1234_5678;
        dato_b = 32'h0000_BEEF;
        req_a  = 1'b1;
        req_b  = 1'b1;
        tick();
        n_cmp++;
        if (gnt_a4 !== 1'b1) begin
            n_fail++;
            $display("FAIL handoff_first: got gnt_a=%b expected 1", gnt_a4);
        end
        req_a = 1'b0;
        tick();
        for (int i = 0; i < 2; i++) begin
            n_cmp++;
            if (obs[i] !== {4'b0101, 32'h0000_BEEF}) begin
                n_fail++;
                $display("FAIL handoff dut%0d: got %h expected %h", i, obs[i], {4'b0101, 32'h0000_BEEF});
            end
        end
    endtask

    task automatic test_b_only();
        do_reset();
        req_b = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            dato_b = $urandom;
            tick();
            for (int i = 0; i < 2; i++) begin
                n_cmp++;
                if (obs[i] !== {4'b0101, dato_b}) begin
                    n_fail++;
                    $display("FAIL b_only dut%0d cyc%0d: got %h expected %h", i, k, obs[i], {4'b0101, dato_b});
                end
            end
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        req_b = 1'b1;
        tick();
        tick();
        n_cmp++;
        if (gnt_b4 !== 1'b1) begin
            n_fail++;
            $display("FAIL async_pre: got gnt_b=%b expected 1", gnt_b4);
        end
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        for (int i = 0; i < 2; i++) begin
            n_cmp++;
            if (obs[i][35:32] !== 4'b0000) begin
                n_fail++;
                $display("FAIL async_reset dut%0d: got ctl=%b expected 0000", i, obs[i][35:32]);
            end
        end
        req_a = 1'b1;
        req_b = 1'b1;
        #2;
        rst_n = 1'b1;
        tick();
        for (int i = 0; i < 2; i++) begin
            n_cmp++;
            if (obs[i] !== {4'b1011, dato_a}) begin
                n_fail++;
                $display("FAIL async_after dut%0d: got %h expected %h", i, obs[i], {4'b1011, dato_a});
            end
        end
    endtask

    task automatic test_idle_hold();
        do_reset();
        req_b = 1'b1;
        tick();
        req_b = 1'b0;
        tick();
        for (int k = 0; k < 3; k++) begin
            dato_a = $urandom;
            dato_b = $urandom;
            #1;
            for (int i = 0; i < 2; i++) begin
                n_cmp++;
                if (obs[i] !== {4'b0000, dato_b}) begin
                    n_fail++;
                    $display("FAIL idle_hold dut%0d: got %h expected %h", i, obs[i], {4'b0000, dato_b});
                end
            end
        end
        req_a = 1'b1;
        req_b = 1'b1;
        tick();
        for (int i = 0; i < 2; i++) begin
            n_cmp++;
            if (obs[i] !== {4'b1011, dato_a}) begin
                n_fail++;
                $display("FAIL idle_tie dut%0d: got %h expected %h", i, obs[i], {4'b1011, dato_a});
            end
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int k = 0; k < 500; k++) begin
            req_a  = ($urandom_range(0, 3) != 0);
            req_b  = ($urandom_range(0, 3) != 0);
            dato_a = $urandom;
            dato_b = $urandom;
            tick();
            for (int i = 0; i < 2; i++) begin
                n_cmp++;
                if (obs[i] !== exp_vec(i)) begin
                    n_fail++;
                    $display("FAIL random dut%0d cyc%0d: got %h expected %h", i, k, obs[i], exp_vec(i));
                end
                n_cmp++;
                if (obs[i][35] && obs[i][34]) begin
                    n_fail++;
                    $display("FAIL onehot dut%0d cyc%0d: got gnt_a=1 gnt_b=1 expected at most one", i, k);
                end
            end
        end
    endtask

    initial begin
        rst_n  = 1'b0;
        req_a  = 1'b0;
        req_b  = 1'b0;
        dato_a = '0;
        dato_b = '0;
        test_reset();
        test_single_a();
        test_rotation();
        test_handoff();
        test_b_only();
        test_async_reset();
        test_idle_hold();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
